// File: rtl/key_lock_table_controller_if.sv
// Snoopy key-lock bus as seen from one lock controller (master) and the shared arbiter/snooper (slave).
// Handshake: request is a level held from acceptance until the release pulse; grant is sampled
// only while the controller waits for it; conflict is sampled two cycles after the grant cycle.
`timescale 1ns/1ps
interface key_lock_table_controller_if #(
   parameter int KEY_W = 32
);
   logic             snoopy_bus_request;
   logic             snoopy_bus_grant;
   logic             snoopy_bus_release;
   logic             snoop_check_req;
   logic [KEY_W-1:0] snoopy_bus_key_to_be_locked;
   logic             add_conflict_snoopy_to_proc;

   modport master (
      output snoopy_bus_request,
      output snoopy_bus_release,
      output snoop_check_req,
      output snoopy_bus_key_to_be_locked,
      input  snoopy_bus_grant,
      input  add_conflict_snoopy_to_proc
   );

   modport slave (
      input  snoopy_bus_request,
      input  snoopy_bus_release,
      input  snoop_check_req,
      input  snoopy_bus_key_to_be_locked,
      output snoopy_bus_grant,
      output add_conflict_snoopy_to_proc
   );
endinterface

// File: rtl/key_lock_table_controller.sv
// CAM-style key lock table with snoopy-bus acquisition, bounded conflict retry with backoff,
// and release-by-key that runs independently of the acquisition FSM.
`timescale 1ns/1ps
module key_lock_table_controller #(
   parameter int KEY_W       = 32,
   parameter int NUM_LOCKS   = 4,
   parameter int RETRY_WAIT  = 20,
   parameter int MAX_RETRIES = 3
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [KEY_W-1:0]               proc_key,
   input  logic                           proc_obtain_key,
   output logic                           proc_key_grant,
   output logic                           proc_key_blocked,
   input  logic                           proc_key_release,
   input  logic [KEY_W-1:0]               proc_release_key,
   output logic                           proc_key_release_ack,
   output logic                           proc_release_miss,
   output logic                           locks_available,
   output logic [$clog2(NUM_LOCKS+1)-1:0] lock_count,
   output logic                           busy,
   key_lock_table_controller_if.master    bus,
   output logic [NUM_LOCKS*KEY_W-1:0]     locked_key_export,
   output logic [NUM_LOCKS-1:0]           locked_valid_export,
   output logic [2:0]                     fsm_state_dbg
);
   localparam int CNT_W = $clog2(NUM_LOCKS+1);
   localparam int IDX_W = $clog2(NUM_LOCKS);
   localparam int RC_W  = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES+1);
   localparam int BC_W  = $clog2(RETRY_WAIT+1);
   localparam logic [KEY_W-1:0] INVALID_KEY = '1;

   typedef enum logic [2:0] {
      IDLE, WAIT_GRANT, RESPONSE, CHECK, BUS_RELEASE, BACKOFF
   } state_t;

   state_t             state_q, state_d;
   logic               req_q, req_d;
   logic               rel_q, rel_d;
   logic               chk_q, chk_d;
   logic [KEY_W-1:0]   bkey_q, bkey_d;
   logic [KEY_W-1:0]   lkey_q, lkey_d;
   logic [RC_W-1:0]    retry_q, retry_d;
   logic [BC_W-1:0]    bcnt_q, bcnt_d;
   logic               grant_q, grant_d;
   logic               blocked_q, blocked_d;
   logic               ack_q, ack_d;
   logic               miss_q, miss_d;
   logic [KEY_W-1:0]   keys_q [NUM_LOCKS];
   logic [KEY_W-1:0]   keys_d [NUM_LOCKS];
   logic [NUM_LOCKS-1:0] valid_q, valid_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic               obtain_hit;
   logic               rel_hit;
   logic [IDX_W-1:0]   rel_idx;
   logic [IDX_W-1:0]   alloc_idx;
   logic               alloc;
   logic               free_any;

   // Single pass over the table: lowest free slot, self-conflict match, release match.
   always_comb begin
      obtain_hit = 1'b0;
      rel_hit    = 1'b0;
      rel_idx    = '0;
      alloc_idx  = '0;
      for (int i = NUM_LOCKS - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            alloc_idx = IDX_W'(i);
         end
         if (valid_q[i] && (keys_q[i] == proc_key)) begin
            obtain_hit = 1'b1;
         end
         if (valid_q[i] && (keys_q[i] == proc_release_key)) begin
            rel_hit = 1'b1;
            rel_idx = IDX_W'(i);
         end
      end
   end

   assign free_any = ~(&valid_q);

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      rel_d     = 1'b0;
      chk_d     = 1'b0;
      bkey_d    = bkey_q;
      lkey_d    = lkey_q;
      retry_d   = retry_q;
      bcnt_d    = bcnt_q;
      grant_d   = 1'b0;
      blocked_d = 1'b0;
      alloc     = 1'b0;
      case (state_q)
         IDLE: begin
            if (proc_obtain_key) begin
               if (!free_any || (proc_key == INVALID_KEY) || obtain_hit) begin
                  blocked_d = 1'b1;
               end else begin
                  lkey_d  = proc_key;
                  retry_d = '0;
                  req_d   = 1'b1;
                  state_d = WAIT_GRANT;
               end
            end
         end
         WAIT_GRANT: begin
            if (bus.snoopy_bus_grant) begin
               bkey_d  = lkey_q;
               chk_d   = 1'b1;
               state_d = RESPONSE;
            end
         end
         RESPONSE: begin
            state_d = CHECK;
         end
         CHECK: begin
            if (!bus.add_conflict_snoopy_to_proc) begin
               // A slot is guaranteed free: the table can only drain while we hold the bus.
               alloc   = 1'b1;
               grant_d = 1'b1;
               state_d = BUS_RELEASE;
            end else begin
               req_d = 1'b0;
               rel_d = 1'b1;
               if (retry_q < RC_W'(MAX_RETRIES)) begin
                  retry_d = retry_q + 1'b1;
                  bcnt_d  = BC_W'(RETRY_WAIT);
                  state_d = BACKOFF;
               end else begin
                  blocked_d = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         BUS_RELEASE: begin
            req_d   = 1'b0;
            rel_d   = 1'b1;
            state_d = IDLE;
         end
         BACKOFF: begin
            bcnt_d = bcnt_q - 1'b1;
            if (bcnt_q == BC_W'(1)) begin
               req_d   = 1'b1;
               state_d = WAIT_GRANT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Allocation picks from the pre-release free vector, so it never lands on the released slot.
   always_comb begin
      keys_d  = keys_q;
      valid_d = valid_q;
      ack_d   = 1'b0;
      miss_d  = 1'b0;
      if (alloc) begin
         keys_d[alloc_idx]  = lkey_q;
         valid_d[alloc_idx] = 1'b1;
      end
      if (proc_key_release) begin
         if (rel_hit) begin
            keys_d[rel_idx]  = INVALID_KEY;
            valid_d[rel_idx] = 1'b0;
            ack_d            = 1'b1;
         end else begin
            miss_d = 1'b1;
         end
      end
      count_d = '0;
      for (int i = 0; i < NUM_LOCKS; i++) begin
         count_d = count_d + CNT_W'(valid_d[i]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         req_q     <= 1'b0;
         rel_q     <= 1'b0;
         chk_q     <= 1'b0;
         bkey_q    <= '0;
         lkey_q    <= '0;
         retry_q   <= '0;
         bcnt_q    <= '0;
         grant_q   <= 1'b0;
         blocked_q <= 1'b0;
         ack_q     <= 1'b0;
         miss_q    <= 1'b0;
         valid_q   <= '0;
         count_q   <= '0;
         for (int i = 0; i < NUM_LOCKS; i++) begin
            keys_q[i] <= INVALID_KEY;
         end
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         rel_q     <= rel_d;
         chk_q     <= chk_d;
         bkey_q    <= bkey_d;
         lkey_q    <= lkey_d;
         retry_q   <= retry_d;
         bcnt_q    <= bcnt_d;
         grant_q   <= grant_d;
         blocked_q <= blocked_d;
         ack_q     <= ack_d;
         miss_q    <= miss_d;
         valid_q   <= valid_d;
         count_q   <= count_d;
         keys_q    <= keys_d;
      end
   end

   assign proc_key_grant                  = grant_q;
   assign proc_key_blocked                = blocked_q;
   assign proc_key_release_ack            = ack_q;
   assign proc_release_miss               = miss_q;
   assign locks_available                 = free_any;
   assign lock_count                      = count_q;
   assign busy                            = (state_q != IDLE);
   assign fsm_state_dbg                   = state_q;
   assign bus.snoopy_bus_request          = req_q;
   assign bus.snoopy_bus_release          = rel_q;
   assign bus.snoop_check_req             = chk_q;
   assign bus.snoopy_bus_key_to_be_locked = bkey_q;
   assign locked_valid_export             = valid_q;

   for (genvar g = 0; g < NUM_LOCKS; g++) begin : g_export
      assign locked_key_export[g*KEY_W +: KEY_W] = keys_q[g];
   end
endmodule

// File: tb/tb_key_lock_table_controller.sv
// Directed bench: a cycle-indexed timeline model of the lock table and bus protocol, checked every cycle.
`timescale 1ns/1ps
module tb_key_lock_table_controller;
  localparam int KEY_W = 32;
  localparam int NL    = 4;
  localparam int RW    = 4;
  localparam int MAXR  = 2;
  localparam int NC    = 1024;
  localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]       proc_key = '0;
  logic              proc_obtain_key = 1'b0;
  logic              proc_key_grant;
  logic              proc_key_blocked;
  logic              proc_key_release = 1'b0;
  logic [31:0]       proc_release_key = '0;
  logic              proc_key_release_ack;
  logic              proc_release_miss;
  logic              locks_available;
  logic [2:0]        lock_count;
  logic              busy;
  logic [NL*32-1:0]  locked_key_export;
  logic [NL-1:0]     locked_valid_export;
  logic [2:0]        fsm_state_dbg;

  key_lock_table_controller_if #(.KEY_W(KEY_W)) bus ();

  key_lock_table_controller #(
    .KEY_W(KEY_W), .NUM_LOCKS(NL), .RETRY_WAIT(RW), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .proc_key(proc_key), .proc_obtain_key(proc_obtain_key),
    .proc_key_grant(proc_key_grant), .proc_key_blocked(proc_key_blocked),
    .proc_key_release(proc_key_release), .proc_release_key(proc_release_key),
    .proc_key_release_ack(proc_key_release_ack), .proc_release_miss(proc_release_miss),
    .locks_available(locks_available), .lock_count(lock_count), .busy(busy),
    .bus(bus.master),
    .locked_key_export(locked_key_export), .locked_valid_export(locked_valid_export),
    .fsm_state_dbg(fsm_state_dbg)
  );

  // ---------------- stimulus timeline ----------------
  bit          d_obtain [NC];
  bit          d_grant  [NC];
  bit          d_conf   [NC];
  bit          d_rel    [NC];
  logic [31:0] d_key    [NC];
  logic [31:0] d_relkey [NC];

  // ---------------- expected timeline / model ----------------
  bit          e_req [NC];
  bit          e_busy[NC];
  bit          e_rel [NC];
  bit          e_chk [NC];
  bit          e_grant[NC];
  bit          e_blk [NC];
  bit          e_ack [NC];
  bit          e_miss[NC];
  bit          bkey_ev [NC];
  logic [31:0] bkey_val[NC];
  bit          alloc_ev [NC];
  logic [31:0] alloc_key[NC];
  bit          relk_ev  [NC];
  logic [31:0] relk_key [NC];

  logic [31:0] m_key [NL];
  bit          m_valid[NL];
  logic [31:0] m_bkey;

  int cyc = 0;
  bit chk_en = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  logic [127:0] x_keys;
  logic [3:0]   x_valid;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < NL; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  function automatic bit m_holds(input logic [31:0] k);
    for (int i = 0; i < NL; i++) if (m_valid[i] && m_key[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NL; i++) begin
        x_keys[i*32 +: 32] = m_key[i];
        x_valid[i]         = m_valid[i];
      end
      cmp("request",   128'(bus.snoopy_bus_request), 128'(e_req[cyc]));
      cmp("busy",      128'(busy),                   128'(e_busy[cyc]));
      cmp("bus_rel",   128'(bus.snoopy_bus_release), 128'(e_rel[cyc]));
      cmp("snoop_chk", 128'(bus.snoop_check_req),    128'(e_chk[cyc]));
      cmp("grant",     128'(proc_key_grant),         128'(e_grant[cyc]));
      cmp("blocked",   128'(proc_key_blocked),       128'(e_blk[cyc]));
      cmp("rel_ack",   128'(proc_key_release_ack),   128'(e_ack[cyc]));
      cmp("rel_miss",  128'(proc_release_miss),      128'(e_miss[cyc]));
      cmp("bus_key",   128'(bus.snoopy_bus_key_to_be_locked), 128'(m_bkey));
      cmp("export",    128'(locked_key_export),      x_keys);
      cmp("valid",     128'(locked_valid_export),    128'(x_valid));
      cmp("lock_count",128'(lock_count),             128'(m_count()));
      cmp("locks_av",  128'(locks_available),        128'(m_count() < NL));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= NC - 8) begin
      n_err++;
      $display("FAIL cycle_budget cyc=%0d got=overrun want=<%0d", cyc, NC - 8);
      $fatal(1, "cycle budget exhausted");
    end
    if (bkey_ev[cyc]) m_bkey = bkey_val[cyc];
    if (alloc_ev[cyc]) begin
      for (int i = 0; i < NL; i++) begin
        if (!m_valid[i]) begin
          m_valid[i] = 1'b1;
          m_key[i]   = alloc_key[cyc];
          break;
        end
      end
    end
    if (relk_ev[cyc]) begin
      for (int i = 0; i < NL; i++) begin
        if (m_valid[i] && m_key[i] == relk_key[cyc]) begin
          m_valid[i] = 1'b0;
          m_key[i]   = ALL1;
        end
      end
    end
    proc_obtain_key                 = d_obtain[cyc];
    proc_key                        = d_obtain[cyc] ? d_key[cyc] : '0;
    proc_key_release                = d_rel[cyc];
    proc_release_key                = d_rel[cyc] ? d_relkey[cyc] : '0;
    bus.snoopy_bus_grant            = d_grant[cyc];
    bus.add_conflict_snoopy_to_proc = d_conf[cyc];
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  // Timeline from obtain: request at c+1; grant at g gives snoop at g+1, conflict at g+2,
  // grant/blocked at g+3; success releases at g+4, conflict releases at g+3 then backs off RW.
  task automatic plan_lock(input logic [31:0] key, input int gdelay, input int nconf,
                           input bit with_rel, input logic [31:0] rkey, output int done);
    int c, rs, g;
    c = cyc + 1;
    d_obtain[c] = 1'b1;
    d_key[c]    = key;
    done        = c + 3;
    if (m_count() == NL || key == ALL1 || m_holds(key)) begin
      e_blk[c+1] = 1'b1;
      return;
    end
    rs = c + 1;
    for (int a = 0; a <= MAXR; a++) begin
      g = rs + gdelay;
      d_grant[g] = 1'b1;
      for (int k = rs; k <= g + 2; k++) begin
        e_req[k]  = 1'b1;
        e_busy[k] = 1'b1;
      end
      e_chk[g+1]    = 1'b1;
      bkey_ev[g+1]  = 1'b1;
      bkey_val[g+1] = key;
      if (a >= nconf) begin
        e_req[g+3]     = 1'b1;
        e_busy[g+3]    = 1'b1;
        e_grant[g+3]   = 1'b1;
        alloc_ev[g+3]  = 1'b1;
        alloc_key[g+3] = key;
        e_rel[g+4]     = 1'b1;
        if (with_rel) begin
          d_rel[g+2]    = 1'b1;
          d_relkey[g+2] = rkey;
          if (m_holds(rkey)) begin
            relk_ev[g+3]  = 1'b1;
            relk_key[g+3] = rkey;
            e_ack[g+3]    = 1'b1;
          end else begin
            e_miss[g+3] = 1'b1;
          end
        end
        done = g + 6;
        return;
      end
      d_conf[g+2] = 1'b1;
      e_rel[g+3]  = 1'b1;
      if (a == MAXR) begin
        e_blk[g+3] = 1'b1;
        done = g + 5;
        return;
      end
      for (int k = g + 3; k < g + 3 + RW; k++) e_busy[k] = 1'b1;
      rs = g + 3 + RW;
    end
  endtask

  task automatic do_lock(input logic [31:0] key, input int gdelay, input int nconf);
    int done;
    plan_lock(key, gdelay, nconf, 1'b0, '0, done);
    run_to(done);
  endtask

  task automatic do_lock_rel(input logic [31:0] key, input int gdelay, input logic [31:0] rkey);
    int done;
    plan_lock(key, gdelay, 0, 1'b1, rkey, done);
    run_to(done);
  endtask

  task automatic do_release(input logic [31:0] key);
    int r;
    r = cyc + 1;
    d_rel[r]    = 1'b1;
    d_relkey[r] = key;
    if (m_holds(key)) begin
      relk_ev[r+1]  = 1'b1;
      relk_key[r+1] = key;
      e_ack[r+1]    = 1'b1;
    end else begin
      e_miss[r+1] = 1'b1;
    end
    run_to(r + 2);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.snoopy_bus_grant            = 1'b0;
    bus.add_conflict_snoopy_to_proc = 1'b0;
    for (int i = 0; i < NL; i++) begin
      m_key[i]   = ALL1;
      m_valid[i] = 1'b0;
    end
    m_bkey = '0;

    repeat (2) @(posedge clk);
    #1;
    cmp("rst_request", 128'(bus.snoopy_bus_request), 128'(0));
    cmp("rst_bus_rel", 128'(bus.snoopy_bus_release), 128'(0));
    cmp("rst_snoop",   128'(bus.snoop_check_req), 128'(0));
    cmp("rst_bus_key", 128'(bus.snoopy_bus_key_to_be_locked), 128'(0));
    cmp("rst_grant",   128'(proc_key_grant), 128'(0));
    cmp("rst_blocked", 128'(proc_key_blocked), 128'(0));
    cmp("rst_ack",     128'(proc_key_release_ack), 128'(0));
    cmp("rst_miss",    128'(proc_release_miss), 128'(0));
    cmp("rst_busy",    128'(busy), 128'(0));
    cmp("rst_count",   128'(lock_count), 128'(0));
    cmp("rst_avail",   128'(locks_available), 128'(1));
    cmp("rst_export",  128'(locked_key_export), {128{1'b1}});
    cmp("rst_valid",   128'(locked_valid_export), 128'(0));
    cmp("rst_state",   128'(fsm_state_dbg), 128'(0));
    reset_n = 1'b1;
    chk_en  = 1'b1;
    run_to(3);

    // single lock, grant three cycles after obtain
    do_lock(32'h10, 2, 0);
    cmp("lit_slot0_10", 128'(locked_key_export[31:0]), 128'(32'h10));
    cmp("lit_count_1",  128'(lock_count), 128'(1));
    do_release(32'h10);

    // fill, out-of-order release, refill lowest slot, then reject while full
    do_lock(32'hA, 0, 0);
    do_lock(32'hB, 1, 0);
    do_lock(32'hC, 2, 0);
    do_lock(32'hD, 0, 0);
    do_release(32'hB);
    do_lock(32'hE, 1, 0);
    cmp("lit_slot0_A", 128'(locked_key_export[31:0]),  128'(32'hA));
    cmp("lit_slot1_E", 128'(locked_key_export[63:32]), 128'(32'hE));
    cmp("lit_slot2_C", 128'(locked_key_export[95:64]), 128'(32'hC));
    cmp("lit_slot3_D", 128'(locked_key_export[127:96]), 128'(32'hD));
    do_lock(32'hF, 0, 0);
    cmp("lit_full_cnt",   128'(lock_count), 128'(4));
    cmp("lit_full_avail", 128'(locks_available), 128'(0));
    do_release(32'hA);
    do_release(32'hE);
    do_release(32'hC);
    do_release(32'hD);

    // self-conflict and reserved key
    do_lock(32'h5, 1, 0);
    do_lock(32'h5, 0, 0);
    do_lock(ALL1, 0, 0);
    do_release(32'h5);

    // conflict on every attempt: first try plus MAXR retries, then blocked
    do_lock(32'h20, 1, 3);
    cmp("lit_retry_cnt", 128'(lock_count), 128'(0));

    // conflict once, success on retry
    do_lock(32'h30, 0, 1);
    cmp("lit_slot0_30", 128'(locked_key_export[31:0]),  128'(32'h30));
    cmp("lit_slot1_inv",128'(locked_key_export[63:32]), 128'(ALL1));

    do_release(32'h77);

    // release a held key in the CHECK-success cycle
    do_lock_rel(32'h40, 1, 32'h30);
    cmp("lit_slot0_inv", 128'(locked_key_export[31:0]),  128'(ALL1));
    cmp("lit_slot1_40",  128'(locked_key_export[63:32]), 128'(32'h40));
    cmp("lit_net_cnt",   128'(lock_count), 128'(1));

    // asynchronous reset while waiting for grant
    chk_en = 1'b0;
    @(posedge clk); #1;
    proc_obtain_key = 1'b1;
    proc_key        = 32'h50;
    @(posedge clk); #1;
    proc_obtain_key = 1'b0;
    proc_key        = '0;
    cmp("pre_rst_request", 128'(bus.snoopy_bus_request), 128'(1));
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    cmp("mid_rst_request", 128'(bus.snoopy_bus_request), 128'(0));
    cmp("mid_rst_bus_rel", 128'(bus.snoopy_bus_release), 128'(0));
    cmp("mid_rst_busy",    128'(busy), 128'(0));
    cmp("mid_rst_export",  128'(locked_key_export), {128{1'b1}});
    cmp("mid_rst_valid",   128'(locked_valid_export), 128'(0));
    cmp("mid_rst_count",   128'(lock_count), 128'(0));
    cmp("mid_rst_state",   128'(fsm_state_dbg), 128'(0));
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
